// File: rtl/alu_mem_seq.sv
// Register-mapped ALU slave: reads return 1 cycle after request; single-cycle ops finish 1 cycle after start, MUL after DATA_WIDTH.
// No backpressure: operand/CTRL writes while busy are dropped and raise sticky err; reads are always accepted.
module alu_mem_seq #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    rd_wr,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [2*DATA_WIDTH-1:0] res_out,
  output logic                    res_valid,
  output logic                    busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t         state;
  logic [W-1:0]   opa, opb;
  logic [2:0]     opcode, op_q;
  logic           done, err;
  logic [2*W-1:0] mcand, acc, acc_nxt, alu_res, b_ext;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  step;
  logic [W-1:0]   rd_mux;
  logic           wr_acc, rd_acc, ctrl_wr, start_ok, start_bad, busy_wr, stat_rd;

  always_comb begin
    wr_acc    = enable && !rd_wr;
    rd_acc    = enable && rd_wr;
    ctrl_wr   = wr_acc && (addr == ADDR_WIDTH'(2));
    start_ok  = ctrl_wr && (state == IDLE) && wr_data[3] && (wr_data[2:0] != OP_RSVD);
    start_bad = ctrl_wr && (state == IDLE) && wr_data[3] && (wr_data[2:0] == OP_RSVD);
    busy_wr   = wr_acc && (addr < ADDR_WIDTH'(3)) && (state == EXEC);
    stat_rd   = rd_acc && (addr == ADDR_WIDTH'(3));
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_WIDTH'(0): rd_mux = opa;
      ADDR_WIDTH'(1): rd_mux = opb;
      ADDR_WIDTH'(2): rd_mux = {{(W-3){1'b0}}, opcode};
      ADDR_WIDTH'(3): rd_mux = {{(W-3){1'b0}}, err, done, busy};
      ADDR_WIDTH'(4): rd_mux = res_out[W-1:0];
      ADDR_WIDTH'(5): rd_mux = res_out[2*W-1:W];
      default:        rd_mux = '0;
    endcase
  end

  // mcand holds the zero-extended A operand; mplier holds B until the multiplier consumes it
  always_comb begin
    b_ext   = {{W{1'b0}}, mplier};
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = mcand + b_ext;
      OP_SUB:  alu_res = mcand - b_ext;
      OP_AND:  alu_res = mcand & b_ext;
      OP_OR:   alu_res = mcand | b_ext;
      OP_XOR:  alu_res = mcand ^ b_ext;
      OP_PASS: alu_res = mcand;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      opcode    <= '0;
      op_q      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      step      <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      res_out   <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      rd_valid  <= rd_acc;
      if (rd_acc) rd_data <= rd_mux;
      // clear first so a flag set later on this same edge wins
      if (stat_rd) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (wr_acc && state == IDLE) begin
        if (addr == ADDR_WIDTH'(0)) opa    <= wr_data;
        if (addr == ADDR_WIDTH'(1)) opb    <= wr_data;
        if (addr == ADDR_WIDTH'(2)) opcode <= wr_data[2:0];
      end
      if (busy_wr || start_bad) err <= 1'b1;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= EXEC;
            busy   <= 1'b1;
            op_q   <= wr_data[2:0];
            mcand  <= {{W{1'b0}}, opa};
            mplier <= opb;
            acc    <= '0;
            step   <= '0;
          end
        end
        EXEC: begin
          if (op_q != OP_MUL) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_out   <= alu_res;
            res_valid <= 1'b1;
            done      <= 1'b1;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + CW'(1);
            if (step == CW'(W - 1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              res_out   <= acc_nxt;
              res_valid <= 1'b1;
              done      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mem_seq.sv
// Bench for alu_mem_seq: directed scenarios then random bus traffic against a transaction-level model.
module tb_alu_mem_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rd_wr = 1'b0;
  logic [2:0]  addr = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [15:0] res_out;
  logic        res_valid;
  logic        busy;

  alu_mem_seq #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rd_wr(rd_wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .res_out(res_out), .res_valid(res_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [7:0]  m_opa, m_opb, m_rd;
  logic [2:0]  m_op;
  logic        m_done, m_err, m_rv, m_resv;
  logic [15:0] m_res, m_pend;
  int          m_left;

  function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return 16'(a) + 16'(b);
      3'd1:    return 16'(a) - 16'(b);
      3'd2:    return 16'(a & b);
      3'd3:    return 16'(a | b);
      3'd4:    return 16'(a ^ b);
      3'd5:    return 16'(a) * 16'(b);
      3'd6:    return 16'(a);
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_opa = 0; m_opb = 0; m_op = 0; m_done = 0; m_err = 0;
    m_rv = 0; m_resv = 0; m_res = 0; m_pend = 0; m_left = 0; m_rd = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".busy"}, busy, m_left > 0);
    chk({tag, ".rd_valid"}, rd_valid, m_rv);
    chk({tag, ".rd_data"}, rd_data, m_rd);
    chk({tag, ".res_out"}, res_out, m_res);
    chk({tag, ".res_valid"}, res_valid, m_resv);
  endtask

  // one bus cycle: drive, advance the model across the edge, then compare
  task automatic bus(input logic en, input logic rw, input logic [2:0] a, input logic [7:0] d, input string tag);
    logic       pre_busy;
    logic [7:0] rv;
    enable = en; rd_wr = rw; addr = a; wr_data = d;
    pre_busy = m_left > 0;
    case (a)
      3'd0:    rv = m_opa;
      3'd1:    rv = m_opb;
      3'd2:    rv = {5'b0, m_op};
      3'd3:    rv = {5'b0, m_err, m_done, pre_busy};
      3'd4:    rv = m_res[7:0];
      3'd5:    rv = m_res[15:8];
      default: rv = 8'h00;
    endcase
    @(posedge clk);
    m_rv = en && rw;
    m_resv = 1'b0;
    if (m_rv) m_rd = rv;
    if (m_rv && a == 3'd3) begin
      m_done = 1'b0;
      m_err  = 1'b0;
    end
    if (pre_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_res = m_pend; m_done = 1'b1; m_resv = 1'b1;
      end
    end
    if (en && !rw && a <= 3'd2) begin
      if (pre_busy) m_err = 1'b1;
      else if (a == 3'd0) m_opa = d;
      else if (a == 3'd1) m_opb = d;
      else begin
        m_op = d[2:0];
        if (d[3]) begin
          if (d[2:0] == 3'd7) m_err = 1'b1;
          else begin
            m_pend = ref_op(d[2:0], m_opa, m_opb);
            m_left = (d[2:0] == 3'd5) ? 8 : 1;
          end
        end
      end
    end
    #1;
    check_outputs(tag);
    enable = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.rd_valid", rd_valid, 0);
    chk("rst.res_out", res_out, 0);
    chk("rst.res_valid", res_valid, 0);
    reset = 1'b1;

    // reset three cycles into a multiply
    bus(1, 0, 0, 8'hFF, "t1");
    bus(1, 0, 1, 8'hFF, "t1");
    bus(1, 0, 2, 8'h0D, "t1");
    for (int i = 0; i < 3; i++) bus(0, 0, 0, 0, "t1");
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t1.busy", busy, 0);
    chk("t1.res_out", res_out, 0);
    chk("t1.rd_data", rd_data, 0);
    #1 reset = 1'b1;
    bus(1, 1, 3, 0, "t1");
    chk("t1.stat", rd_data, 8'h00);

    // SUB wraps to 2W bits; STAT read clears done
    bus(1, 0, 0, 8'h03, "t2");
    bus(1, 0, 1, 8'h05, "t2");
    bus(1, 0, 2, 8'h09, "t2");
    bus(0, 0, 0, 0, "t2");
    chk("t2.res", res_out, 16'hFFFE);
    chk("t2.res_valid", res_valid, 1);
    bus(0, 0, 0, 0, "t2");
    chk("t2.res_valid_off", res_valid, 0);
    bus(1, 1, 3, 0, "t2");
    chk("t2.stat0", rd_data, 8'h02);
    bus(1, 1, 3, 0, "t2");
    chk("t2.stat1", rd_data, 8'h00);

    // multiply 8 cycles
    bus(1, 0, 0, 8'hFF, "t3");
    bus(1, 0, 1, 8'hFF, "t3");
    bus(1, 0, 2, 8'h0D, "t3");
    for (int i = 0; i < 7; i++) begin
      bus(0, 0, 0, 0, "t3");
      chk("t3.busy_hold", busy, 1);
    end
    bus(0, 0, 0, 0, "t3");
    chk("t3.busy_end", busy, 0);
    chk("t3.res", res_out, 16'hFE01);
    bus(1, 1, 4, 0, "t3");
    chk("t3.res_lo", rd_data, 8'h01);
    bus(1, 1, 5, 0, "t3");
    chk("t3.res_hi", rd_data, 8'hFE);

    // operand write while busy is dropped
    bus(1, 0, 2, 8'h0D, "t4");
    bus(1, 0, 0, 8'h11, "t4");
    for (int i = 0; i < 8; i++) bus(0, 0, 0, 0, "t4");
    chk("t4.res", res_out, 16'hFE01);
    bus(1, 1, 0, 0, "t4");
    chk("t4.opa", rd_data, 8'hFF);
    bus(1, 1, 3, 0, "t4");
    chk("t4.err", rd_data[2], 1);

    // ADD carry and reserved opcode
    bus(1, 0, 0, 8'hFF, "t5");
    bus(1, 0, 1, 8'h01, "t5");
    bus(1, 0, 2, 8'h08, "t5");
    bus(0, 0, 0, 0, "t5");
    chk("t5.add", res_out, 16'h0100);
    bus(1, 0, 2, 8'h0F, "t5");
    chk("t5.rsvd_busy", busy, 0);
    bus(0, 0, 0, 0, "t5");
    chk("t5.rsvd_res", res_out, 16'h0100);
    bus(1, 1, 3, 0, "t5");
    chk("t5.err", rd_data[2], 1);

    // unmapped read and disabled read
    bus(1, 1, 7, 0, "t6");
    chk("t6.rd7", rd_data, 8'h00);
    chk("t6.rv7", rd_valid, 1);
    bus(0, 1, 0, 0, "t6");
    chk("t6.rv_off", rd_valid, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic       en, rw;
      logic [2:0] a;
      logic [7:0] d;
      en = ($urandom % 4) != 0;
      rw = $urandom % 2;
      a  = 3'($urandom % 8);
      d  = 8'($urandom);
      if (!rw && a == 3'd2) d[3] = ($urandom % 4) != 0;
      bus(en, rw, a, d, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
